// File: rtl/float_div.sv
// rtl/float_div.sv - sequential IEEE-754 single-precision restoring divider
// One quotient bit per cycle; fixed 26-cycle latency from accept to write-back.
module float_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] S,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        div_by_zero
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        sign_q, sign_d;
  logic [7:0]  a_exp_q, a_exp_d;
  logic [7:0]  b_exp_q, b_exp_d;
  logic [23:0] m2_q, m2_d;
  logic [24:0] rem_q, rem_d;
  logic [24:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] s_q, s_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        dbz_q, dbz_d;

  logic signed [9:0] exp_raw;
  logic signed [9:0] exp_norm;
  logic [22:0]       frac;
  logic [24:0]       m2_ext;

  assign m2_ext  = {1'b0, m2_q};
  assign exp_raw = $signed({2'b00, a_exp_q}) - $signed({2'b00, b_exp_q}) + 10'sd127;

  // A quotient below 2^24 means m1 < m2: the leading one sits one place lower.
  always_comb begin
    exp_norm = exp_raw;
    frac     = quo_q[22:0];
    if (quo_q[24]) begin
      frac = quo_q[23:1];
    end else begin
      exp_norm = exp_raw - 10'sd1;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    a_exp_d = a_exp_q;
    b_exp_d = b_exp_q;
    m2_d    = m2_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sign_d  = A[31] ^ B[31];
          a_exp_d = A[30:23];
          b_exp_d = B[30:23];
          m2_d    = {1'b1, B[22:0]};
          rem_d   = {2'b01, A[22:0]};
          quo_d   = '0;
          cnt_d   = '0;
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        if (rem_q >= m2_ext) begin
          quo_d = {quo_q[23:0], 1'b1};
          rem_d = (rem_q - m2_ext) << 1;
        end else begin
          quo_d = {quo_q[23:0], 1'b0};
          rem_d = rem_q << 1;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd24) begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        dbz_d   = 1'b0;
        if (a_exp_q == 8'hFF || b_exp_q == 8'hFF) begin
          s_d   = 32'h7F80_0000;
          ovf_d = 1'b1;
        end else if (b_exp_q == 8'h00) begin
          s_d   = {sign_q, 8'hFF, 23'h0};
          ovf_d = 1'b1;
          dbz_d = 1'b1;
        end else if (a_exp_q == 8'h00) begin
          s_d   = 32'h0;
          ovf_d = 1'b0;
        end else if (exp_norm >= 10'sd255) begin
          s_d   = {sign_q, 8'hFF, 23'h0};
          ovf_d = 1'b1;
        end else if (exp_norm <= 10'sd0) begin
          s_d   = 32'h0;
          ovf_d = 1'b0;
        end else begin
          s_d   = {sign_q, exp_norm[7:0], frac};
          ovf_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      a_exp_q <= '0;
      b_exp_q <= '0;
      m2_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      a_exp_q <= a_exp_d;
      b_exp_q <= b_exp_d;
      m2_q    <= m2_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign S           = s_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_float_div.sv
// tb/tb_float_div.sv - scoreboard bench for float_div
// Driver pushes expected results; a negedge monitor pops them on each done.
module tb_float_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] S;
  logic        busy, done, overflow, div_by_zero;

  float_div dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .S(S),
    .busy(busy), .done(done), .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic        ovf;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests = tests + 1;
    if (act !== req) begin
      fails = fails + 1;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: exact integer quotient of the significands, truncated, then packed.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    logic   sign;
    int     ae, be, e;
    longint n, d, q, f;
    sign = a[31] ^ b[31];
    ae = int'(a[30:23]);
    be = int'(b[30:23]);
    if (ae == 255 || be == 255) return {1'b0, 1'b1, 32'h7F80_0000};
    if (be == 0) return {1'b1, 1'b1, sign, 8'hFF, 23'h0};
    if (ae == 0) return {1'b0, 1'b0, 32'h0};
    n = (longint'(a[22:0]) + 64'd8388608) * 64'd16777216;
    d = longint'(b[22:0]) + 64'd8388608;
    q = n / d;
    e = ae - be + 127;
    if (q >= 64'd16777216) begin
      f = (q / 2) % 64'd8388608;
    end else begin
      f = q % 64'd8388608;
      e = e - 1;
    end
    if (e >= 255) return {1'b0, 1'b1, sign, 8'hFF, 23'h0};
    if (e <= 0) return {1'b0, 1'b0, 32'h0};
    return {1'b0, 1'b0, sign, e[7:0], f[22:0]};
  endfunction

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      if (sb.size() == 0) begin
        tests = tests + 1;
        fails = fails + 1;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no result pending", cyc);
      end else begin
        e = sb.pop_front();
        check("S", S, e.s);
        check("overflow", {31'b0, overflow}, {31'b0, e.ovf});
        check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Waits for busy=0, pulses start for one accepting edge, optionally queues the expectation.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [33:0] ev, input bit push);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles, expected 0", n);
    end
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    if (push) begin
      e.s = ev[31:0];
      e.ovf = ev[32];
      e.dbz = ev[33];
      e.cyc = cyc + 26;
      sb.push_back(e);
    end
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0] ex;
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0: ex = 8'h00;
      1: ex = 8'hFF;
      2: ex = 8'($urandom_range(1, 20));
      3: ex = 8'($urandom_range(235, 254));
      default: ex = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), ex, 23'($urandom)};
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [33:0] ev;
  } vec_t;

  vec_t dir[$];

  initial begin
    exp_t e;
    int   c0, n;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    check("rst_S", S, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_ovf", {31'b0, overflow}, 32'h0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'h0);
    rst = 1'b0;

    dir.push_back('{32'h40C0_0000, 32'h4000_0000, {2'b00, 32'h4040_0000}});
    dir.push_back('{32'h3F80_0000, 32'h4040_0000, {2'b00, 32'h3EAA_AAAA}});
    dir.push_back('{32'hC0C0_0000, 32'h4000_0000, {2'b00, 32'hC040_0000}});
    dir.push_back('{32'h3F80_0000, 32'h0000_0000, {2'b11, 32'h7F80_0000}});
    dir.push_back('{32'h7F80_0000, 32'h3F80_0000, {2'b01, 32'h7F80_0000}});
    dir.push_back('{32'h7F00_0000, 32'h0080_0000, {2'b01, 32'h7F80_0000}});
    dir.push_back('{32'h0080_0000, 32'h7F00_0000, {2'b00, 32'h0000_0000}});
    dir.push_back('{32'h0000_0000, 32'h3F80_0000, {2'b00, 32'h0000_0000}});
    foreach (dir[i]) issue(dir[i].a, dir[i].b, dir[i].ev, 1'b1);

    // start while busy must be ignored
    issue(32'h40C0_0000, 32'h4000_0000, {2'b00, 32'h4040_0000}, 1'b1);
    repeat (4) @(negedge clk);
    A = 32'h3F80_0000;
    B = 32'h4040_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_during_div", {31'b0, busy}, 32'h1);

    // start held high: second accept on the edge after write-back
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    A = 32'h40C0_0000;
    B = 32'h4000_0000;
    start = 1'b1;
    @(negedge clk);
    c0 = cyc;
    A = 32'hC0C0_0000;
    B = 32'h4000_0000;
    e = '{32'h4040_0000, 1'b0, 1'b0, c0 + 26};
    sb.push_back(e);
    e = '{32'hC040_0000, 1'b0, 1'b0, c0 + 53};
    sb.push_back(e);
    repeat (27) @(negedge clk);
    start = 1'b0;
    check("busy_second_op", {31'b0, busy}, 32'h1);

    // reset mid-operation abandons the divide
    issue(32'h7F00_0000, 32'h0080_0000, 34'h0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_S", S, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_done", {31'b0, done}, 32'h0);
    check("midrst_ovf", {31'b0, overflow}, 32'h0);
    check("midrst_dbz", {31'b0, div_by_zero}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    issue(32'h40C0_0000, 32'h4000_0000, {2'b00, 32'h4040_0000}, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = rnd_fp();
      rb = rnd_fp();
      issue(ra, rb, model(ra, rb), 1'b1);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
